pzcorebus_response_arbiter: RTL and testbench
=============================================

# pzcorebus_response_arbiter

Merges the response channels of up to `REQUESTERS` pzcorebus response sources onto one downstream response channel. It uses round-robin arbitration with burst locking, followed by a single registered output stage. It sits where several slices or slave agents return responses toward one master, typically directly upstream of a response slicer. It owns the scheduling of the shared response datapath; payload content is passed through untouched.

## Interface
- `REQUESTERS`, default 2: number of response sources; legal range 2..16.
- `WIDTH`, default 64: packed response width, excluding the last flag.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_sresp_valid`  in  REQUESTERS: per-source response valid.
- `o_mresp_accept`  out  REQUESTERS: per-source accept; one-hot or zero.
- `i_sresp`  in  REQUESTERS×WIDTH: per-source packed response.
- `i_sresp_last`  in  REQUESTERS: per-source last-beat flag.
- `o_sresp_valid`  out  1: merged response valid (registered).
- `i_mresp_accept`  in  1: downstream accept.
- `o_sresp`  out  WIDTH: merged response (registered).
- `o_sresp_last`  out  1: merged last flag (registered).
- `o_grant`  out  clog2(REQUESTERS), min 1: index of the source that produced the current output beat.

## Operation
- **Reset values.** `o_sresp_valid`=0, `o_sresp`=0, `o_sresp_last`=0, `o_grant`=0, `o_mresp_accept`=0. Internal state resets to: RR pointer=0, lock=0, locked index=0.
- **Load condition.** `load_ok` = !`o_sresp_valid` || `i_mresp_accept`.
- **Accept.** When `load_ok` is true and a winner W exists, `o_mresp_accept[W]`=1 in the same cycle. The output stage then loads `i_sresp[W]`, `i_sresp_last[W]` and W, and sets `o_sresp_valid`=1.
- **Drain.** When `load_ok` is true through `i_mresp_accept` and no source is selected, `o_sresp_valid` clears.
- **Winner, unlocked.** The winner is the first valid source found searching from the RR pointer upward, wrapping modulo `REQUESTERS`.
- **Winner, locked.** Only the locked index may win. If that source has valid=0, there is no winner and the arbiter waits; it never switches mid-burst.
- **State machine.** Two states, IDLE (lock=0) and BURST (lock=1).
  - IDLE→BURST on an accepted beat with last=0; the locked index becomes W.
  - BURST→IDLE on an accepted beat from the locked source with last=1.
  - IDLE→IDLE on an accepted beat with last=1 (single-beat response).
- **RR pointer.** Updates to (W+1) mod `REQUESTERS` only on an accepted beat with last=1. Wrap from `REQUESTERS`-1 goes to 0.
- **Source obligations.** Sources hold valid and payload stable until accepted. The arbiter does not check this.
- **Simultaneous drain and load.** Allowed in one cycle; this gives full throughput of one beat per cycle.
- **Reset mid-burst.** Returns to IDLE. The output beat is discarded and the pointer is cleared. No accept is asserted in the reset cycle.

## Timing
- Latency is 1 cycle from accept at the input to valid at the output.
- Throughput is 1 beat per cycle under continuous `i_mresp_accept`=1.
- `o_mresp_accept` is combinational from `i_sresp_valid`, `i_mresp_accept` and state. There is no combinational path from `i_sresp` to any output.
- With `i_mresp_accept`=0 and output valid, all `o_mresp_accept` are 0 and the output holds stable.

## Configuration
- **Macro `PZCOREBUS_RESPONSE_ARBITER_BURST_LOCK_EN`.**
- **Defined:** burst locking operates as described in Operation.
- **Undefined:**
  - lock is never set, and arbitration occurs on every beat;
  - the RR pointer advances to W+1 on every accepted beat;
  - `i_sresp_last` is still registered and passed to `o_sresp_last`, but has no effect on scheduling.

## Test plan
- **Reset values:** assert `i_rst` with all sources valid → `o_sresp_valid`=0, `o_sresp`=0, `o_grant`=0 and all accepts 0 during reset. After release, the first grant goes to source 0.
- **Single source, full throughput:** source 1 sends a 4-beat burst (payloads 0xA0..0xA3, last on beat 3), `i_mresp_accept`=1 → four consecutive output beats one cycle later, in order, with `o_grant`=1 and last only on 0xA3.
- **Round robin:** sources 0, 1 and 2 each continuously offer single-beat responses → grant order 0,1,2,0,1,2. No source gets two grants while another valid source waits.
- **Burst lock** (macro defined): source 0 starts a 3-beat burst; source 1 is valid from the cycle after source 0's first beat, and source 0 deasserts valid for 2 cycles mid-burst → source 1 is not accepted until source 0's last beat is accepted, and source 1 is then granted next. With the macro undefined, source 1 is granted in the first gap.
- **Backpressure:** hold `i_mresp_accept`=0 for 3 cycles with output valid (payload 0x55) → `o_sresp` stays 0x55, all accepts stay 0, and no beat is lost or duplicated after release.
- **Reset mid-burst:** pulse `i_rst` after beat 2 of a 4-beat burst from source 2 → the next cycle shows output invalid and lock cleared. Afterwards source 0 can win without waiting for source 2's last beat.

Source files
------------

// File: rtl/pzcorebus_response_arbiter.sv
// pzcorebus_response_arbiter: round-robin merge of REQUESTERS response channels onto one registered output
// Ports: i_clk/i_rst (sync, active-high); per-source i_sresp_valid/i_sresp/i_sresp_last in and
// o_mresp_accept out; merged o_sresp_valid/o_sresp/o_sresp_last/o_grant out with i_mresp_accept in.
// Optional macro PZCOREBUS_RESPONSE_ARBITER_BURST_LOCK_EN: hold the grant on one source until its last beat.
module pzcorebus_response_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int WIDTH = 64,
  localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [REQUESTERS-1:0]            i_sresp_valid,
  output logic [REQUESTERS-1:0]            o_mresp_accept,
  input  logic [REQUESTERS-1:0][WIDTH-1:0] i_sresp,
  input  logic [REQUESTERS-1:0]            i_sresp_last,
  output logic                             o_sresp_valid,
  input  logic                             i_mresp_accept,
  output logic [WIDTH-1:0]                 o_sresp,
  output logic                             o_sresp_last,
  output logic [GW-1:0]                    o_grant
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t           state_q, state_d;
  logic             valid_q, valid_d, last_q, last_d, found, take, load_ok;
  logic [WIDTH-1:0] data_q, data_d;
  logic [GW-1:0]    grant_q, grant_d, rr_q, rr_d, lock_idx_q, lock_idx_d, win, idx, nxt;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    // descending scan so the source closest above the pointer is the last (winning) assignment
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_q) + i) % REQUESTERS);
      if (i_sresp_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    if (state_q == BURST) begin
      found = i_sresp_valid[lock_idx_q];
      win = lock_idx_q;
    end
    load_ok = !valid_q || i_mresp_accept;
    take = load_ok && found && !i_rst;
    nxt = (win == GW'(REQUESTERS - 1)) ? '0 : win + GW'(1);
    valid_d = take || (valid_q && !load_ok);
    data_d = take ? i_sresp[win] : data_q;
    last_d = take ? i_sresp_last[win] : last_q;
    grant_d = take ? win : grant_q;
`ifdef PZCOREBUS_RESPONSE_ARBITER_BURST_LOCK_EN
    state_d = take ? (i_sresp_last[win] ? IDLE : BURST) : state_q;
    lock_idx_d = take ? win : lock_idx_q;
    rr_d = (take && i_sresp_last[win]) ? nxt : rr_q;
`else
    state_d = IDLE;
    lock_idx_d = '0;
    rr_d = take ? nxt : rr_q;
`endif
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      grant_q <= '0;
      rr_q <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end
  assign o_mresp_accept = take ? (REQUESTERS'(1) << win) : '0;
  assign o_sresp_valid = valid_q;
  assign o_sresp = data_q;
  assign o_sresp_last = last_q;
  assign o_grant = grant_q;
endmodule

// File: tb/tb_pzcorebus_response_arbiter.sv
// tb_pzcorebus_response_arbiter: directed checks of the response arbiter with three sources
module tb_pzcorebus_response_arbiter;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      valid = '0;
  logic [2:0]      acc;
  logic [2:0][7:0] sresp = '0;
  logic [2:0]      last = '0;
  logic            ov;
  logic            macc = 1'b1;
  logic [7:0]      od;
  logic            ol;
  logic [1:0]      og;
  int              n_cmp = 0;
  int              n_err = 0;
  pzcorebus_response_arbiter #(.REQUESTERS(3), .WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_sresp_valid(valid), .o_mresp_accept(acc),
    .i_sresp(sresp), .i_sresp_last(last), .o_sresp_valid(ov), .i_mresp_accept(macc),
    .o_sresp(od), .o_sresp_last(ol), .o_grant(og)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    last = '0;
    sresp = '0;
    macc = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    valid = 3'b111;
    last = 3'b111;
    sresp = {8'h33, 8'h22, 8'h11};
    macc = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_cmp += 4;
    if (ov !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ov); end
    if (od !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", od); end
    if (og !== 2'd0) begin n_err++; $display("FAIL rst_grant: got %0d want 0", og); end
    if (acc !== 3'b000) begin n_err++; $display("FAIL rst_accept: got %b want 000", acc); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (acc !== 3'b001) begin n_err++; $display("FAIL rst_first_accept: got %b want 001", acc); end
    tick();
    valid = '0;
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b1 || od !== 8'h11 || og !== 2'd0) begin
      n_err++; $display("FAIL rst_first_beat: got v=%b d=%h g=%0d want v=1 d=11 g=0", ov, od, og);
    end
  endtask
  task automatic test_single_source();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      valid = 3'b010;
      sresp[1] = 8'hA0 + 8'(k);
      last[1] = (k == 3);
      @(negedge clk);
      n_cmp++;
      if (acc !== 3'b010) begin n_err++; $display("FAIL single_accept[%0d]: got %b want 010", k, acc); end
      if (k > 0) begin
        n_cmp++;
        if (ov !== 1'b1 || od !== 8'hA0 + 8'(k - 1) || og !== 2'd1 || ol !== 1'b0) begin
          n_err++; $display("FAIL single_beat[%0d]: got v=%b d=%h g=%0d l=%b want v=1 d=%h g=1 l=0", k - 1, ov, od, og, ol, 8'hA0 + 8'(k - 1));
        end
      end
      tick();
    end
    valid = '0;
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b1 || od !== 8'hA3 || og !== 2'd1 || ol !== 1'b1) begin
      n_err++; $display("FAIL single_last: got v=%b d=%h g=%0d l=%b want v=1 d=a3 g=1 l=1", ov, od, og, ol);
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    valid = 3'b111;
    last = 3'b111;
    sresp = {8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (acc !== 3'(1 << (k % 3))) begin n_err++; $display("FAIL rr_accept[%0d]: got %b want %b", k, acc, 3'(1 << (k % 3))); end
      if (k > 0) begin
        n_cmp++;
        if (og !== 2'((k - 1) % 3) || od !== 8'h10 + 8'((k - 1) % 3)) begin
          n_err++; $display("FAIL rr_grant[%0d]: got g=%0d d=%h want g=%0d", k - 1, og, od, (k - 1) % 3);
        end
      end
      tick();
    end
    valid = '0;
  endtask
  task automatic test_burst_lock();
    logic [2:0] exp [6];
    logic [5:0] v0 = 6'b011001;
    logic [5:0] l0 = 6'b010000;
    logic [7:0] d0 [6] = '{8'hE0, 8'h00, 8'h00, 8'hE1, 8'hE2, 8'h00};
    logic       s1_done = 1'b0;
`ifdef PZCOREBUS_RESPONSE_ARBITER_BURST_LOCK_EN
    exp = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
`else
    exp = '{3'b001, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000};
`endif
    do_reset();
    sresp[1] = 8'hF0;
    last[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      valid[0] = v0[c];
      sresp[0] = d0[c];
      last[0] = l0[c];
      valid[1] = (c >= 1) && !s1_done;
      @(negedge clk);
      n_cmp++;
      if (acc !== exp[c]) begin n_err++; $display("FAIL lock_accept[%0d]: got %b want %b", c, acc, exp[c]); end
      if (acc[1]) s1_done = 1'b1;
      tick();
    end
    valid = '0;
  endtask
  task automatic test_backpressure();
    do_reset();
    valid = 3'b100;
    sresp[2] = 8'h55;
    last = 3'b111;
    @(negedge clk);
    n_cmp++;
    if (acc !== 3'b100) begin n_err++; $display("FAIL bp_first_accept: got %b want 100", acc); end
    tick();
    valid = 3'b001;
    sresp[0] = 8'h66;
    macc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ov !== 1'b1 || od !== 8'h55 || acc !== 3'b000) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h acc=%b want v=1 d=55 acc=000", k, ov, od, acc);
      end
      tick();
    end
    macc = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (acc !== 3'b001 || od !== 8'h55) begin n_err++; $display("FAIL bp_release: got acc=%b d=%h want acc=001 d=55", acc, od); end
    tick();
    valid = '0;
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b1 || od !== 8'h66 || og !== 2'd0) begin
      n_err++; $display("FAIL bp_next: got v=%b d=%h g=%0d want v=1 d=66 g=0", ov, od, og);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b0) begin n_err++; $display("FAIL bp_drain: got v=%b want 0", ov); end
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    valid = 3'b100;
    last = 3'b000;
    for (int k = 0; k < 2; k++) begin
      sresp[2] = 8'hC0 + 8'(k);
      @(negedge clk);
      n_cmp++;
      if (acc !== 3'b100) begin n_err++; $display("FAIL mid_accept[%0d]: got %b want 100", k, acc); end
      tick();
    end
    sresp[2] = 8'hC2;
    valid = 3'b101;
    last[0] = 1'b1;
    sresp[0] = 8'h77;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (acc !== 3'b000) begin n_err++; $display("FAIL mid_rst_accept: got %b want 000", acc); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (ov !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", ov); end
    if (acc !== 3'b001) begin n_err++; $display("FAIL mid_src0_wins: got %b want 001", acc); end
    tick();
    valid = '0;
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b1 || od !== 8'h77 || og !== 2'd0) begin
      n_err++; $display("FAIL mid_src0_beat: got v=%b d=%h g=%0d want v=1 d=77 g=0", ov, od, og);
    end
  endtask
  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
